sub_bytes_seq: RTL

- Iterative AES SubBytes / InvSubBytes stage. It sits directly upstream of the ShiftRows stage in the round datapath, and its out_data feeds the ShiftRows input unchanged.
- It processes one 128-bit state per transaction and shares NUM_SBOX S-box instances across the 16 bytes, so the area/latency trade is set by the parameter.
- It uses valid/ready handshakes on both sides.
- State byte layout: byte i (i = 0..15, column-major s[r][c] with i = 4c + r) occupies bits [8i+7:8i]. s0_0 is at the LSB.

---
 rtl/sub_bytes_seq.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/sub_bytes_seq.sv
// Iterative AES SubBytes / InvSubBytes: NUM_SBOX shared S-boxes walk the 16 state bytes in place,
// with valid/ready handshakes on both sides.
module sub_bytes_seq #(
  parameter int unsigned NUM_SBOX = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int unsigned N_CYC = 16 / NUM_SBOX;
  localparam int unsigned CW    = (N_CYC > 1) ? $clog2(N_CYC) : 1;

  if (!(NUM_SBOX == 1 || NUM_SBOX == 2 || NUM_SBOX == 4 || NUM_SBOX == 8 || NUM_SBOX == 16))
  begin : g_bad_num_sbox
    $error("sub_bytes_seq: NUM_SBOX must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {StIdle, StSub, StDone} state_e;

  state_e                     state_q, state_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic                       inv_q, inv_d;
  logic [15:0][7:0]           data_q, data_d;
  logic [NUM_SBOX-1:0][3:0]   sub_idx;
  logic [NUM_SBOX-1:0][7:0]   sub_in, sub_out;
  logic                       capture, last_cyc;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 == a^-1 in GF(2^8); 0 maps to 0 naturally.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r, p;
    r = 8'h01;
    p = a;
    for (int i = 0; i < 7; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
    logic [15:0] aa;
    aa = {a, a};
    return aa[15-n -: 8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a, input logic inv);
    logic [7:0] t;
    if (!inv) begin
      t = gf_inv(a);
      return t ^ rotl(t, 1) ^ rotl(t, 2) ^ rotl(t, 3) ^ rotl(t, 4) ^ 8'h63;
    end else begin
      t = rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05;
      return gf_inv(t);
    end
  endfunction

  always_comb begin
    sub_idx = '0;
    sub_in  = '0;
    for (int k = 0; k < NUM_SBOX; k++) begin
      sub_idx[k] = 4'(int'(cnt_q) * int'(NUM_SBOX) + k);
      sub_in[k]  = data_q[sub_idx[k]];
    end
  end

  for (genvar k = 0; k < NUM_SBOX; k++) begin : g_sbox
    assign sub_out[k] = sbox(sub_in[k], inv_q);
  end

  assign last_cyc = (cnt_q == CW'(N_CYC - 1));
  assign capture  = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = StSub;
      StSub:   if (last_cyc) state_d = StDone;
      StDone:  if (out_ready) state_d = in_valid ? StSub : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      StIdle:  in_ready = 1'b1;
      StSub:   busy = 1'b1;
      StDone: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: ;
    endcase
  end

  // Gate the working register so a half-substituted state never reaches ShiftRows.
  assign out_data = out_valid ? data_q : '0;

  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    inv_d  = inv_q;
    if (capture) begin
      data_d = in_data;
      inv_d  = in_inv;
      cnt_d  = '0;
    end else if (state_q == StSub) begin
      for (int k = 0; k < NUM_SBOX; k++) data_d[sub_idx[k]] = sub_out[k];
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      cnt_q  <= '0;
      inv_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
      inv_q  <= inv_d;
    end
  end

endmodule
